// File: rtl/count_updn_mod.sv
// count_updn_mod: parametrised up/down counter with modulo terminal value,
// wrap or saturate mode, terminal-count flag and registered wrap pulse.
module count_updn_mod #(
    parameter int WIDTH    = 8,
    parameter int MAX_VAL  = (1 << WIDTH) - 1,
    parameter bit SATURATE = 1'b0
) (
    input  logic             Clk,
    input  logic             Res,
    input  logic             En,
    input  logic             Up,
    input  logic             Load,
    input  logic [WIDTH-1:0] cnt_in,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MAX_W = MAX_VAL[WIDTH-1:0];

    logic [WIDTH-1:0] tgl;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_val;
    logic             at_end;
    logic             carry;

    // Toggle chain: bit i flips when every lower bit is 1 (up) or 0 (down).
    always_comb begin
        tgl   = '0;
        carry = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            tgl[i] = carry;
            carry  = carry & (Up ? cnt[i] : ~cnt[i]);
        end
    end

    assign at_end = Up ? (cnt == MAX_W) : (cnt == '0);
    assign tc     = En & at_end;

    always_comb begin
        step_val = cnt ^ tgl;
        if (at_end) begin
            if (SATURATE)
                step_val = cnt;
            else
                step_val = Up ? '0 : MAX_W;
        end
    end

    // A full-range terminal value cannot be exceeded, so no clamp is built.
    if (MAX_VAL == (1 << WIDTH) - 1) begin : g_full
        assign load_val = cnt_in;
    end else begin : g_clamp
        assign load_val = (cnt_in > MAX_W) ? MAX_W : cnt_in;
    end

    always_ff @(posedge Clk) begin
        if (Res) begin
            cnt  <= '0;
            wrap <= 1'b0;
        end else if (Load) begin
            cnt  <= load_val;
            wrap <= 1'b0;
        end else begin
            wrap <= tc;
            if (En)
                cnt <= step_val;
        end
    end

endmodule
